// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory block.
package imem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } imem_state_e;

  localparam logic [31:0] NOP         = 32'h00000013;
  localparam int          DEF_DEPTH   = 1024;
  localparam int          DEF_LATENCY = 2;
  // Wide enough for the largest legal LATENCY (15).
  localparam int          CNT_W       = 4;

endpackage

// File: rtl/imem_array.sv
// Word storage: one synchronous write port and one registered read port.
// The read port samples before the write lands, so a same-edge hit returns old data.
module imem_array #(
  parameter  int bits  = 32,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [bits-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [bits-1:0] rdata
);

  logic [bits-1:0] r_mem [DEPTH];
  logic [bits-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/instr_mem.sv
// Fixed-latency instruction fetch memory: IDLE/BUSY FSM, latency counter, output registers.
// Optional misaligned-fetch error output is built when IMEM_MISALIGN_ERR_EN is defined.
module instr_mem
  import imem_pkg::*;
#(
  parameter int bits    = 32,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            proc_req,
  input  logic [bits-1:0] addr,
  output logic            mem_rdy,
  output logic            valid,
  output logic [bits-1:0] rdata,
  input  logic            ld_en,
  input  logic [bits-1:0] ld_addr,
  input  logic [bits-1:0] ld_data,
`ifdef IMEM_MISALIGN_ERR_EN
  output logic            err,
`endif
  output imem_state_e     o_dbg_state
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic            FAST     = (LATENCY == 1);

  imem_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic [bits-1:0]  r_rdata;
  logic             r_nop;

  logic             w_accept;
  logic             w_fire;
  logic             w_rd_oor;
  logic             w_ld_oor;
  logic             w_mis;
  logic [bits-1:0]  w_arr_rdata;
  logic             w_unused;

  assign w_rd_oor = (addr >> (AW + 2)) != '0;
  assign w_ld_oor = (ld_addr >> (AW + 2)) != '0;
  assign w_unused = ^{addr[1:0], ld_addr[1:0]};

`ifdef IMEM_MISALIGN_ERR_EN
  logic r_mis;
  logic r_err;
  assign w_mis = (addr[1:0] != 2'b00);
  assign err   = r_err;
`else
  assign w_mis = 1'b0;
`endif

  // With LATENCY=1 the block stays ready while a response is in flight.
  assign mem_rdy  = (r_state == IDLE) || FAST;
  assign w_accept = proc_req && mem_rdy;
  assign w_fire   = (r_state == BUSY) && (r_cnt == '0);

  imem_array #(
    .bits  (bits),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (ld_en && !w_ld_oor),
    .waddr (ld_addr[AW+1:2]),
    .wdata (ld_data),
    .re    (w_accept),
    .raddr (addr[AW+1:2]),
    .rdata (w_arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_nop   <= 1'b0;
`ifdef IMEM_MISALIGN_ERR_EN
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_valid <= w_fire;
      if (w_fire) r_rdata <= r_nop ? bits'(NOP) : w_arr_rdata;
`ifdef IMEM_MISALIGN_ERR_EN
      r_err <= w_fire && r_mis;
      if (w_accept) r_mis <= w_mis;
`endif
      if (w_accept) begin
        r_state <= BUSY;
        r_cnt   <= CNT_LOAD;
        r_nop   <= w_rd_oor || w_mis;
      end else if (r_state == BUSY) begin
        if (r_cnt == '0) r_state <= IDLE;
        else             r_cnt   <= r_cnt - 1'b1;
      end
    end
  end

  assign valid       = r_valid;
  assign rdata       = r_rdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem with three instances (LATENCY 2, 1, 3) and a response scoreboard.
module tb_instr_mem;
  import imem_pkg::*;

  logic        clk;
  logic        rst;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        proc_req [3];
  logic [31:0] addr     [3];
  logic        mem_rdy  [3];
  logic        valid    [3];
  logic [31:0] rdata    [3];
  logic        err      [3];
  imem_state_e dbg      [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] model [1024];

  // Scoreboard: one entry per accepted fetch, popped on the matching valid pulse.
  logic [31:0] exp_q[$];
  int          exp_unit_q[$];
  int          exp_cyc_q[$];
  logic        exp_err_q[$];

  instr_mem #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .proc_req(proc_req[0]), .addr(addr[0]),
    .mem_rdy(mem_rdy[0]), .valid(valid[0]), .rdata(rdata[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef IMEM_MISALIGN_ERR_EN
    .err(err[0]),
`endif
    .o_dbg_state(dbg[0])
  );

  instr_mem #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .proc_req(proc_req[1]), .addr(addr[1]),
    .mem_rdy(mem_rdy[1]), .valid(valid[1]), .rdata(rdata[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef IMEM_MISALIGN_ERR_EN
    .err(err[1]),
`endif
    .o_dbg_state(dbg[1])
  );

  instr_mem #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .proc_req(proc_req[2]), .addr(addr[2]),
    .mem_rdy(mem_rdy[2]), .valid(valid[2]), .rdata(rdata[2]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef IMEM_MISALIGN_ERR_EN
    .err(err[2]),
`endif
    .o_dbg_state(dbg[2])
  );

`ifndef IMEM_MISALIGN_ERR_EN
  initial begin
    for (int i = 0; i < 3; i++) err[i] = 1'b0;
  end
`endif

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, want completion");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int u);
    case (u)
      0:       return 2;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int u, input logic [31:0] d, input logic e, input int c);
    exp_q.push_back(d);
    exp_unit_q.push_back(u);
    exp_err_q.push_back(e);
    exp_cyc_q.push_back(c);
  endtask

  // Driver tasks
  task automatic load(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    if ((a >> 12) == 0) model[a[11:2]] = d;
  endtask

  task automatic fetch1(input int u, input logic [31:0] a, input logic [31:0] d, input logic e);
    @(negedge clk);
    chk("rdy_before_req", {31'b0, mem_rdy[u]}, 32'd1);
    proc_req[u] = 1'b1; addr[u] = a;
    @(posedge clk); #1;
    push(u, d, e, cyc + lat_of(u));
    proc_req[u] = 1'b0;
    @(negedge clk);
    chk("rdy_accept_cycle", {31'b0, mem_rdy[u]}, (lat_of(u) == 1) ? 32'd1 : 32'd0);
    if (lat_of(u) > 1) begin
      @(negedge clk);
      chk("rdy_busy_cycle", {31'b0, mem_rdy[u]}, 32'd0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
  endtask

  // Monitor: every valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      for (int u = 0; u < 3; u++) begin
        if (valid[u] === 1'b1) begin
          checks++;
          assert (exp_q.size() != 0 && exp_unit_q[0] == u) else begin
            errors++;
            $error("FAIL spurious_valid: unit=%0d observed valid=1 expected valid=0 (pending=%0d)",
                   u, exp_q.size());
          end
          if (exp_q.size() != 0 && exp_unit_q[0] == u) begin
            chk("rdata", rdata[u], exp_q.pop_front());
            chk("valid_cycle", cyc, exp_cyc_q.pop_front());
            void'(exp_unit_q.pop_front());
`ifdef IMEM_MISALIGN_ERR_EN
            chk("err", {31'b0, err[u]}, {31'b0, exp_err_q.pop_front()});
`else
            void'(exp_err_q.pop_front());
`endif
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] old_w;
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int u = 0; u < 3; u++) begin proc_req[u] = 1'b0; addr[u] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("reset_mem_rdy", {31'b0, mem_rdy[u]}, 32'd1);
      chk("reset_valid", {31'b0, valid[u]}, 32'd0);
      chk("reset_rdata", rdata[u], 32'd0);
      chk("reset_state", {31'b0, dbg[u]}, {31'b0, IDLE});
`ifdef IMEM_MISALIGN_ERR_EN
      chk("reset_err", {31'b0, err[u]}, 32'd0);
`endif
    end
    rst = 1'b0;

    load(32'h0, 32'h00500093);
    for (int i = 1; i < 8; i++) load(32'(4 * i), $urandom);
    load(32'h0FFC, $urandom);

    // Basic latency-2 fetch, then back-to-back on the valid cycle
    fetch1(0, 32'h0, model[0], 1'b0);
    fetch1(0, 32'h4, model[1], 1'b0);
    drain();

    // Out-of-range preload must be dropped, not aliased onto word 0
    load(32'h1000, 32'hBAD0BAD0);
    fetch1(0, 32'h0, model[0], 1'b0);
    fetch1(0, 32'h1000, NOP, 1'b0);
    fetch1(0, 32'h0FFC, model[1023], 1'b0);
`ifdef IMEM_MISALIGN_ERR_EN
    fetch1(0, 32'h2, NOP, 1'b1);
`else
    fetch1(0, 32'h2, model[0], 1'b0);
`endif
    drain();

    // Same-edge accept and write on word 3 returns old data
    @(negedge clk);
    old_w = model[3];
    proc_req[0] = 1'b1; addr[0] = 32'hC;
    ld_en = 1'b1; ld_addr = 32'hC; ld_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    push(0, old_w, 1'b0, cyc + 2);
    proc_req[0] = 1'b0; ld_en = 1'b0;
    model[3] = 32'hDEADBEEF;
    drain();
    fetch1(0, 32'hC, 32'hDEADBEEF, 1'b0);
    drain();

    // Latency 1 with request held high: one response per cycle
    @(negedge clk);
    proc_req[1] = 1'b1; addr[1] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      push(1, model[i], 1'b0, cyc + 1);
      chk("l1_rdy_held", {31'b0, mem_rdy[1]}, 32'd1);
      if (i < 2) addr[1] = 32'(4 * (i + 1));
      else       proc_req[1] = 1'b0;
    end
    drain();

    // Write after acceptance must not disturb the pending response
    old_w = model[4];
    fetch1(2, 32'h10, old_w, 1'b0);
    load(32'h10, 32'h13572468);
    drain();
    fetch1(2, 32'h10, 32'h13572468, 1'b0);
    drain();

    // Reset one cycle after acceptance drops the request
    @(negedge clk);
    proc_req[2] = 1'b1; addr[2] = 32'h0;
    @(posedge clk); #1;
    proc_req[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy_mem_rdy", {31'b0, mem_rdy[2]}, 32'd1);
    chk("rst_busy_rdata", rdata[2], 32'd0);
    chk("rst_busy_valid", {31'b0, valid[2]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_state", {31'b0, dbg[2]}, {31'b0, IDLE});

    // Array contents survive reset
    fetch1(2, 32'h0, model[0], 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
